// File: rtl/fracnet_prod_accum_pkg.sv
// Shared definitions for the fracnet product accumulator: default widths
// and the controller state encoding.
package fracnet_prod_accum_pkg;

  // Default datapath widths. An ACC_W of PROD_W + CNT_W holds the largest
  // possible sum (max product times max term count) without wrapping.
  localparam int DEF_PROD_W = 16;
  localparam int DEF_CNT_W  = 10;
  localparam int DEF_ACC_W  = DEF_PROD_W + DEF_CNT_W;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_OUTPUT = 2'd2
  } state_t;

endpackage

// File: rtl/fracnet_prod_accum_if.sv
// Handshake bundle between the 11x5 multiplier stage / result consumer and
// the product accumulator. The accumulator uses the slave view; whoever
// drives the products and consumes the result uses the master view.
interface fracnet_prod_accum_if
  import fracnet_prod_accum_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int ACC_W  = DEF_ACC_W
);

  // Job control
  logic              start;
  logic [CNT_W-1:0]  num_terms;
  logic              busy;

  // Product stream in
  logic [PROD_W-1:0] prod_data;
  logic              prod_valid;
  logic              prod_ready;

  // Result out
  logic [ACC_W-1:0]  acc_data;
  logic              acc_valid;
  logic              acc_ready;

  modport master (
    output start, num_terms, prod_data, prod_valid, acc_ready,
    input  busy, prod_ready, acc_data, acc_valid
  );

  modport slave (
    input  start, num_terms, prod_data, prod_valid, acc_ready,
    output busy, prod_ready, acc_data, acc_valid
  );

endinterface

// File: rtl/fracnet_prod_accum.sv
// Product accumulator: sums a programmed number of unsigned products from
// the multiplier stage and presents the total on a valid/ready output.
// Controller, term counter and accumulator all live in this one module;
// every output is driven straight from a register.
module fracnet_prod_accum
  import fracnet_prod_accum_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  fracnet_prod_accum_if.slave   bus
);

  state_t             state_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   num_q;
  logic [ACC_W-1:0]   acc_data_q;
  logic               acc_valid_q;
  logic               prod_ready_q;
  logic               busy_q;

  logic [ACC_W-1:0]   acc_sum_d;
  logic               last_term_d;
  logic               prod_hs_d;

  // Running sum with the incoming product zero-extended; wraps modulo 2^ACC_W.
  assign acc_sum_d   = acc_q + ACC_W'(bus.prod_data);
  // The handshake that completes the job is the one seen with the counter
  // at num_terms-1 (num_q is never 0 while in ST_ACCUM).
  assign last_term_d = (cnt_q == (num_q - CNT_W'(1)));
  // prod_ready_q is only ever high in ST_ACCUM, so this is the handshake.
  assign prod_hs_d   = bus.prod_valid & prod_ready_q;

  // Controller, counter and accumulator; reset wins over every other event.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q      <= ST_IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      num_q        <= '0;
      acc_data_q   <= '0;
      acc_valid_q  <= 1'b0;
      prod_ready_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            if (bus.num_terms != '0) begin
              num_q        <= bus.num_terms;
              prod_ready_q <= 1'b1;
              state_q      <= ST_ACCUM;
            end else begin
              // Empty job: publish a zero sum without touching the stream.
              acc_data_q  <= '0;
              acc_valid_q <= 1'b1;
              state_q     <= ST_OUTPUT;
            end
          end
        end

        ST_ACCUM: begin
          if (prod_hs_d) begin
            acc_q <= acc_sum_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_term_d) begin
              acc_data_q   <= acc_sum_d;
              acc_valid_q  <= 1'b1;
              prod_ready_q <= 1'b0;
              state_q      <= ST_OUTPUT;
            end
          end
        end

        ST_OUTPUT: begin
          // acc_data_q is frozen here until the consumer takes it.
          if (bus.acc_ready) begin
            acc_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end

        default: begin
          state_q      <= ST_IDLE;
          acc_valid_q  <= 1'b0;
          prod_ready_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.prod_ready = prod_ready_q;
  assign bus.acc_data   = acc_data_q;
  assign bus.acc_valid  = acc_valid_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_fracnet_prod_accum.sv
// Directed bench for fracnet_prod_accum: a table of accumulation jobs with
// hand-computed sums, plus hand-written reset and priority sequences.
module tb_fracnet_prod_accum;

  localparam int PROD_W = 16;
  localparam int CNT_W  = 10;
  localparam int ACC_W  = 26;

  logic clk;
  logic rst;

  fracnet_prod_accum_if #(.PROD_W(PROD_W), .CNT_W(CNT_W), .ACC_W(ACC_W)) bus ();

  fracnet_prod_accum #(.PROD_W(PROD_W), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .ap_clk (clk),
    .ap_rst (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else             n_pass++;
  endtask

  typedef struct {
    string       name;
    int          n;      // num_terms
    int          p0;     // first product
    int          step;   // product increment per term
    logic [15:0] gap;    // prod_valid pattern, bit k used on offer cycle k
    int          stall;  // cycles acc_ready held low once acc_valid is up
    bit          poke;   // pulse start during ACCUM and OUTPUT
    int          exp;    // hand-computed sum
  } vec_t;

  vec_t vecs[8];

  // One full job: start, feed products, check latency/sum, stall, release.
  task automatic run_vec(input vec_t v);
    int          idx = 0;
    int          cyc = 0;
    int          budget;
    bit          rdy_ok = 1'b1;
    bit          vld_ok = 1'b1;
    bit          hold_ok = 1'b1;
    logic [31:0] held;
    logic [3:0]  gi;
    budget = v.n * 4 + 20;

    @(negedge clk);
    bus.start     = 1'b1;
    bus.num_terms = CNT_W'(v.n);
    @(negedge clk);
    bus.start     = 1'b0;
    bus.num_terms = CNT_W'(v.n) ^ 10'h2A5;   // latched value must be used
    chk({v.name, "_busy"}, 32'(bus.busy), 32'd1);

    if (v.n != 0) begin
      while (idx < v.n && cyc < budget) begin
        if (bus.prod_ready !== 1'b1) rdy_ok = 1'b0;
        if (bus.acc_valid  !== 1'b0) vld_ok = 1'b0;
        gi = 4'(cyc);
        bus.prod_valid = v.gap[gi];
        bus.prod_data  = PROD_W'(v.p0 + idx * v.step);
        if (v.poke && cyc == 1) begin
          bus.start     = 1'b1;
          bus.num_terms = 10'd7;
        end else begin
          bus.start = 1'b0;
        end
        @(negedge clk);
        if (bus.prod_valid) idx++;
        cyc++;
      end
      bus.prod_valid = 1'b0;
      bus.start      = 1'b0;
      chk({v.name, "_handshakes"}, 32'(idx), 32'(v.n));
      chk({v.name, "_ready_in_accum"}, 32'(rdy_ok), 32'd1);
      chk({v.name, "_novalid_in_accum"}, 32'(vld_ok), 32'd1);
    end

    // One cycle after the final handshake (or after start for n=0).
    chk({v.name, "_acc_valid"}, 32'(bus.acc_valid), 32'd1);
    chk({v.name, "_prod_ready_low"}, 32'(bus.prod_ready), 32'd0);
    chk({v.name, "_acc_data"}, 32'(bus.acc_data), 32'(v.exp));

    held = 32'(bus.acc_data);
    bus.acc_ready = 1'b0;
    for (int s = 0; s < v.stall; s++) begin
      if (v.poke) begin
        bus.start     = 1'b1;
        bus.num_terms = 10'd2;
      end
      @(negedge clk);
      if (bus.acc_valid !== 1'b1 || 32'(bus.acc_data) !== held) hold_ok = 1'b0;
    end
    if (v.stall > 0) chk({v.name, "_stable_stall"}, 32'(hold_ok), 32'd1);

    bus.acc_ready = 1'b1;
    @(negedge clk);
    bus.acc_ready = 1'b0;
    bus.start     = 1'b0;
    chk({v.name, "_valid_drop"}, 32'(bus.acc_valid), 32'd0);
    chk({v.name, "_idle"}, 32'(bus.busy), 32'd0);
    if (v.poke) begin
      @(negedge clk);
      chk({v.name, "_not_queued"}, 32'(bus.busy), 32'd0);
    end
  endtask

  initial begin
    bit quiet_ok;

    vecs[0] = '{"sum3",      3,    10,    10, 16'hFFFF, 0, 1'b0, 60};
    vecs[1] = '{"single",    1,    5,     0,  16'hFFFF, 0, 1'b0, 5};
    vecs[2] = '{"ramp5",     5,    1,     1,  16'hFFFF, 2, 1'b0, 15};
    vecs[3] = '{"max2",      2,    65535, 0,  16'hFFFF, 0, 1'b0, 131070};
    vecs[4] = '{"gapped4",   4,    100,   50, 16'hFF59, 5, 1'b0, 700};
    vecs[5] = '{"zero",      0,    0,     0,  16'hFFFF, 1, 1'b0, 0};
    vecs[6] = '{"ign_start", 3,    1,     1,  16'hFFFF, 2, 1'b1, 6};
    vecs[7] = '{"full1023",  1023, 65535, 0,  16'hFFFF, 0, 1'b0, 67042305};

    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.num_terms  = '0;
    bus.prod_data  = '0;
    bus.prod_valid = 1'b0;
    bus.acc_ready  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_prod_ready", 32'(bus.prod_ready), 32'd0);
    chk("rst_acc_valid",  32'(bus.acc_valid),  32'd0);
    chk("rst_acc_data",   32'(bus.acc_data),   32'd0);
    chk("rst_busy",       32'(bus.busy),       32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reset after 2 of 5 products: sum abandoned, everything back to zero.
    @(negedge clk);
    bus.start     = 1'b1;
    bus.num_terms = 10'd5;
    @(negedge clk);
    bus.start      = 1'b0;
    bus.prod_valid = 1'b1;
    bus.prod_data  = 16'd3;
    @(negedge clk);
    bus.prod_data  = 16'd4;
    @(negedge clk);
    bus.prod_data  = 16'd9;
    rst            = 1'b1;
    @(negedge clk);
    rst            = 1'b0;
    bus.prod_valid = 1'b0;
    chk("midacc_rst_prod_ready", 32'(bus.prod_ready), 32'd0);
    chk("midacc_rst_acc_valid",  32'(bus.acc_valid),  32'd0);
    chk("midacc_rst_acc_data",   32'(bus.acc_data),   32'd0);
    chk("midacc_rst_busy",       32'(bus.busy),       32'd0);
    quiet_ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.acc_valid !== 1'b0 || bus.busy !== 1'b0) quiet_ok = 1'b0;
    end
    chk("midacc_rst_no_result", 32'(quiet_ok), 32'd1);
    run_vec('{"after_rst", 2, 7, 1, 16'hFFFF, 0, 1'b0, 15});

    // Reset while a result is waiting in OUTPUT.
    @(negedge clk);
    bus.start     = 1'b1;
    bus.num_terms = 10'd0;
    @(negedge clk);
    bus.start = 1'b0;
    chk("out_pending_valid", 32'(bus.acc_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midout_rst_acc_valid", 32'(bus.acc_valid), 32'd0);
    chk("midout_rst_busy",      32'(bus.busy),      32'd0);

    // Reset and start in the same cycle: reset wins.
    @(negedge clk);
    rst           = 1'b1;
    bus.start     = 1'b1;
    bus.num_terms = 10'd3;
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    chk("rst_prio_busy",       32'(bus.busy),       32'd0);
    chk("rst_prio_prod_ready", 32'(bus.prod_ready), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fracnet_prod_accum.md
FRACNET_PROD_ACCUM -- requirements
Module: fracnet_prod_accum

Interface
REQ-001 SHALL have parameter PROD_W, default 16, width of unsigned product input.
REQ-002 SHALL have parameter CNT_W, default 10, width of term-count input; max 1023 terms.
REQ-003 SHALL have parameter ACC_W, default 26, accumulator/result width; PROD_W+CNT_W guarantees no overflow.
REQ-004 SHALL have port ap_clk  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port ap_rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port start  in  1  begin a new accumulation; sampled only in IDLE.
REQ-007 SHALL have port num_terms  in  CNT_W  number of products to sum, latched on accepted start.
REQ-008 SHALL have port prod_data  in  PROD_W  unsigned product from the 11x5 multiplier stage.
REQ-009 SHALL have port prod_valid  in  1  prod_data valid.
REQ-010 SHALL have port prod_ready  out  1  block accepts prod_data this cycle.
REQ-011 SHALL have port acc_data  out  ACC_W  completed unsigned sum.
REQ-012 SHALL have port acc_valid  out  1  acc_data valid.
REQ-013 SHALL have port acc_ready  in  1  downstream accepts acc_data.
REQ-014 SHALL have port busy  out  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, ACCUM, OUTPUT.
REQ-016 IDLE: start=1 with num_terms>0 SHALL latch num_terms, clear accumulator and term counter, go to ACCUM next cycle.
REQ-017 IDLE: start=1 with num_terms=0 SHALL clear accumulator and go directly to OUTPUT with acc_data=0.
REQ-018 prod_ready SHALL be 1 exactly when state=ACCUM (registered, no combinational path from prod_valid).
REQ-019 ACCUM: each handshake (prod_valid & prod_ready) SHALL add zero-extended prod_data to accumulator and increment counter by 1.
REQ-020 ACCUM: cycles with prod_valid=0 SHALL hold accumulator and counter unchanged.
REQ-021 ACCUM: handshake when counter = latched num_terms-1 SHALL register final sum into acc_data and go to OUTPUT next cycle.
REQ-022 Latency: acc_valid SHALL rise the cycle after the final product handshake.
REQ-023 OUTPUT: acc_valid=1 and acc_data SHALL hold stable until acc_ready=1; on that cycle go to IDLE.
REQ-024 start asserted in ACCUM or OUTPUT SHALL be ignored and not queued; num_terms changes outside IDLE SHALL have no effect.
REQ-025 acc_valid SHALL be 0 in IDLE and ACCUM; prod_ready SHALL be 0 in IDLE and OUTPUT.
REQ-026 Arithmetic SHALL be unsigned modulo 2^ACC_W; with defaults, max sum 65535*1023 fits without wrap.

Reset
REQ-027 ap_rst=1 SHALL, on the next edge, force state=IDLE, accumulator=0, counter=0, acc_data=0, acc_valid=0, prod_ready=0, busy=0.
REQ-028 ap_rst mid-ACCUM or mid-OUTPUT SHALL abandon the sum; no acc_valid SHALL be produced for it.
REQ-029 ap_rst SHALL take priority over start and all handshakes in the same cycle.

Structure
REQ-030 State encoding and default widths (PROD_W, CNT_W, ACC_W) SHALL live in the shared fracnet package.
REQ-031 Single module, no sub-module; FSM, counter and accumulator in one file.

Verification
REQ-032 Reset, then start with num_terms=3, products 10,20,30 back-to-back -> acc_valid one cycle after third handshake, acc_data=60.
REQ-033 num_terms=1023, all products 65535 -> acc_data=67042305, no wrap.
REQ-034 num_terms=4, prod_valid gapped (1,0,0,1,1,0,1), acc_ready held 0 for 5 cycles -> acc_data=sum, stable while stalled, IDLE after acc_ready.
REQ-035 start with num_terms=0 -> acc_valid next cycle with acc_data=0, prod_ready never asserted.
REQ-036 start pulsed during ACCUM with different num_terms -> ignored; original count completes with correct sum.
REQ-037 ap_rst after 2 of 5 products -> all outputs 0 next cycle; new start num_terms=2, products 7,8 -> acc_data=15.
